// File: rtl/soc_system_pio_poller_if.sv
// Avalon-MM command/response bundle between the PIO poller (master) and the
// PIO slave it polls.
//   address       master -> slave  byte address
//   read, write   master -> slave  command strobes, held while waitrequest=1
//   writedata     master -> slave  32-bit write data
//   waitrequest   slave -> master  stall; command is accepted when 0
//   readdata      slave -> master  32-bit read data
//   readdatavalid slave -> master  readdata is valid this cycle
interface soc_system_pio_poller_if #(
  parameter int unsigned ADDR_W = 16
);

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic              waitrequest;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    input  waitrequest,
    input  readdata,
    input  readdatavalid
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    output waitrequest,
    output readdata,
    output readdatavalid
  );

endinterface

// File: rtl/soc_system_pio_poller.sv
// Periodic Avalon-MM poller for a PIO input slave. Every POLL_CYCLES clocks it
// reads the data register (reg 0) and the edge-capture register (reg 3); any
// captured edges are reported on event_bits/event_strobe and written back to
// reg 3 so that exactly those bits are cleared.
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   enable        1 = periodic polling runs
//   avm           Avalon-MM master port (address/read/write/writedata out,
//                 waitrequest/readdata/readdatavalid in)
//   sw_state      last data register value read
//   event_bits    edge bits captured by the latest poll that saw edges
//   event_strobe  1-cycle pulse when a poll read nonzero edge bits
//   busy          1 while a poll sequence is in progress
module soc_system_pio_poller #(
  parameter int unsigned       WIDTH       = 4,
  parameter int unsigned       ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       POLL_CYCLES = 50000
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  soc_system_pio_poller_if.master        avm,
  output logic [WIDTH-1:0]               sw_state,
  output logic [WIDTH-1:0]               event_bits,
  output logic                           event_strobe,
  output logic                           busy
);

  localparam int unsigned       CNT_W     = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_TOP   = CNT_W'(POLL_CYCLES - 1);
  localparam logic [ADDR_W-1:0] DATA_ADDR = BASE_ADDR;
  localparam logic [ADDR_W-1:0] EDGE_ADDR = BASE_ADDR + ADDR_W'(12);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_DATA = 3'd1,
    WT_DATA = 3'd2,
    RD_EDGE = 3'd3,
    WT_EDGE = 3'd4,
    WR_CLR  = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] poll_cnt;
  logic             poll_pending;

  logic             tick_c;
  logic             start_c;
  logic             accept_c;
  logic [WIDTH-1:0] rd_bits_c;
  logic             unused_readdata;

  assign tick_c    = enable && (poll_cnt == CNT_TOP);
  assign start_c   = (state == IDLE) && poll_pending && enable;
  assign accept_c  = !avm.waitrequest;
  assign rd_bits_c = avm.readdata[WIDTH-1:0];

  // Upper readdata bits carry nothing for a WIDTH-bit PIO.
  assign unused_readdata = ^avm.readdata;

  // Poll interval timer; parked at 0 while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt <= '0;
    end else if (!enable || (poll_cnt == CNT_TOP)) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + CNT_W'(1);
    end
  end

  // One-deep request flag: ticks arriving while a poll is pending merge.
  // A tick on the same cycle a poll is launched re-arms it, since it belongs
  // to the next interval. Disabling drops any stale request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_pending <= 1'b0;
    end else if (tick_c) begin
      poll_pending <= 1'b1;
    end else if (!enable || start_c) begin
      poll_pending <= 1'b0;
    end
  end

  // Poll sequencer; all bus commands and status outputs are registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      avm.read      <= 1'b0;
      avm.write     <= 1'b0;
      avm.address   <= '0;
      avm.writedata <= '0;
      sw_state      <= '0;
      event_bits    <= '0;
      event_strobe  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      event_strobe <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_c) begin
            state       <= RD_DATA;
            avm.read    <= 1'b1;
            avm.address <= DATA_ADDR;
            busy        <= 1'b1;
          end
        end
        RD_DATA: begin
          if (accept_c) begin
            avm.read <= 1'b0;
            state    <= WT_DATA;
          end
        end
        WT_DATA: begin
          if (avm.readdatavalid) begin
            sw_state    <= rd_bits_c;
            state       <= RD_EDGE;
            avm.read    <= 1'b1;
            avm.address <= EDGE_ADDR;
          end
        end
        RD_EDGE: begin
          if (accept_c) begin
            avm.read <= 1'b0;
            state    <= WT_EDGE;
          end
        end
        WT_EDGE: begin
          if (avm.readdatavalid) begin
            if (rd_bits_c != '0) begin
              // Write back only the bits seen set; later edges survive.
              event_bits    <= rd_bits_c;
              event_strobe  <= 1'b1;
              avm.write     <= 1'b1;
              avm.writedata <= 32'(rd_bits_c);
              state         <= WR_CLR;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        WR_CLR: begin
          if (accept_c) begin
            avm.write <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          avm.read  <= 1'b0;
          avm.write <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Bus protocol invariants.
  a_rd_wr_excl: assert property (@(posedge clk) disable iff (!reset_n)
    !(avm.read && avm.write));

  a_rd_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (avm.read && avm.waitrequest) |=> (avm.read && $stable(avm.address)));

  a_wr_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (avm.write && avm.waitrequest) |=>
      (avm.write && $stable(avm.address) && $stable(avm.writedata)));

endmodule
